// File: rtl/hex_string_serializer_if.sv
// -----------------------------------------------------------------------------
// hex_string_serializer_if
// Bundles the word-in / character-out handshake signals of
// hex_string_serializer.
//
// Signals:
//   in_valid   producer -> serializer  in_data is valid
//   in_ready   serializer -> producer  a word is accepted this cycle
//   in_data    producer -> serializer  word to convert, MS nibble first
//   out_valid  serializer -> sink      out_char is valid
//   out_ready  sink -> serializer      sink accepts out_char this cycle
//   out_char   serializer -> sink      ASCII character
//   out_last   serializer -> sink      out_char is the final character of the word
//   busy       serializer -> observer  a word is in progress
//
// Modports:
//   slave  : the serializer side
//   master : the producer/sink side
// -----------------------------------------------------------------------------
interface hex_string_serializer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            out_char;
    logic                  out_last;
    logic                  busy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_char, out_last, busy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_char, out_last, busy
    );
endinterface

// File: rtl/hex_string_serializer.sv
// -----------------------------------------------------------------------------
// hex_string_serializer
// Accepts one DATA_WIDTH-bit word and emits it as a string of ASCII hex
// characters, most significant nibble first, one character per output
// handshake.
//
// Parameters:
//   DATA_WIDTH     word width, multiple of 4 in 4..64 (NDIG = DATA_WIDTH/4)
//   LOWERCASE      0: digits A-F, 1: digits a-f
//   ZERO_SUPPRESS  1: skip leading zero nibbles, always emit at least one digit
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    hex_string_serializer_if.slave (in_valid/in_ready/in_data,
//          out_valid/out_ready/out_char/out_last, busy)
//
// Build option:
//   HEX_PREFIX_EN  when defined, every word is preceded by "0x", each prefix
//                  character taking its own output handshake.
// -----------------------------------------------------------------------------
module hex_string_serializer #(
    parameter int DATA_WIDTH    = 32,
    parameter bit LOWERCASE     = 1'b0,
    parameter bit ZERO_SUPPRESS = 1'b0
) (
    input logic                    clk,
    input logic                    rst_n,
    hex_string_serializer_if.slave bus
);

    localparam int NDIG  = DATA_WIDTH / 4;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
`ifdef HEX_PREFIX_EN
        PREFIX = 2'd1,
`endif
        DIGITS = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_nxt;
`ifdef HEX_PREFIX_EN
    // 0 while presenting '0', 1 while presenting 'x'
    logic                  pfx_q;
    logic                  pfx_nxt;
`endif

    logic in_hs;
    logic out_hs;

    // Index of the first digit to present: the top nibble, or with zero
    // suppression the most significant nonzero nibble (0 for an all-zero word).
    function automatic logic [IDX_W-1:0] start_index(input logic [DATA_WIDTH-1:0] w);
        logic [IDX_W-1:0] r;
        r = '0;
        if (ZERO_SUPPRESS) begin
            for (int i = 0; i < NDIG; i++) begin
                if (w[i*4 +: 4] != 4'h0) begin
                    r = IDX_W'(i);
                end
            end
        end else begin
            r = IDX_W'(NDIG - 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        logic [7:0] c;
        if (n < 4'd10) begin
            c = 8'h30 + {4'h0, n};
        end else if (LOWERCASE) begin
            c = 8'h61 + {4'h0, n - 4'd10};
        end else begin
            c = 8'h41 + {4'h0, n - 4'd10};
        end
        return c;
    endfunction

    assign in_hs  = bus.in_valid  & bus.in_ready;
    assign out_hs = bus.out_valid & bus.out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            data_q <= '0;
            idx_q  <= '0;
`ifdef HEX_PREFIX_EN
            pfx_q  <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            data_q <= data_nxt;
            idx_q  <= idx_nxt;
`ifdef HEX_PREFIX_EN
            pfx_q  <= pfx_nxt;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        idx_nxt   = idx_q;
`ifdef HEX_PREFIX_EN
        pfx_nxt   = pfx_q;
`endif
        case (state)
            IDLE: begin
                if (in_hs) begin
                    data_nxt  = bus.in_data;
                    idx_nxt   = start_index(bus.in_data);
`ifdef HEX_PREFIX_EN
                    pfx_nxt   = 1'b0;
                    state_nxt = PREFIX;
`else
                    state_nxt = DIGITS;
`endif
                end
            end
`ifdef HEX_PREFIX_EN
            PREFIX: begin
                if (out_hs) begin
                    pfx_nxt = 1'b1;
                    if (pfx_q) begin
                        state_nxt = DIGITS;
                    end
                end
            end
`endif
            DIGITS: begin
                if (out_hs) begin
                    if (idx_q == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt = idx_q - 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: characters come only from the captured word, so they stay
    // stable for as long as the sink stalls.
    always_comb begin
        logic [3:0] nib;
        nib           = data_q[{idx_q, 2'b00} +: 4];
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_char  = 8'h00;
        bus.out_last  = 1'b0;
        bus.busy      = (state != IDLE);
        case (state)
            // Held low while reset is asserted so nothing is offered as accepted.
            IDLE: bus.in_ready = rst_n;
`ifdef HEX_PREFIX_EN
            PREFIX: begin
                bus.out_valid = 1'b1;
                bus.out_char  = pfx_q ? 8'h78 : 8'h30;
            end
`endif
            DIGITS: begin
                bus.out_valid = 1'b1;
                bus.out_char  = hex_char(nib);
                bus.out_last  = (idx_q == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hex_string_serializer.sv
// -----------------------------------------------------------------------------
// tb_hex_string_serializer
// Directed bench for hex_string_serializer. Four instances share clk/rst_n:
//   0: DATA_WIDTH=16 uppercase     1: DATA_WIDTH=16 ZERO_SUPPRESS=1
//   2: DATA_WIDTH=16 LOWERCASE=1   3: DATA_WIDTH=8
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_hex_string_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic        in_valid  [4];
    logic        out_ready [4];
    logic [15:0] in_data   [3];
    logic [7:0]  in_data8;
    logic        ov [4];
    logic        ir [4];
    logic        ol [4];
    logic        bz [4];
    logic [7:0]  oc [4];

    hex_string_serializer_if #(.DATA_WIDTH(16)) bus0 ();
    hex_string_serializer_if #(.DATA_WIDTH(16)) bus1 ();
    hex_string_serializer_if #(.DATA_WIDTH(16)) bus2 ();
    hex_string_serializer_if #(.DATA_WIDTH(8))  bus3 ();

    assign bus0.in_valid = in_valid[0];
    assign bus1.in_valid = in_valid[1];
    assign bus2.in_valid = in_valid[2];
    assign bus3.in_valid = in_valid[3];
    assign bus0.in_data  = in_data[0];
    assign bus1.in_data  = in_data[1];
    assign bus2.in_data  = in_data[2];
    assign bus3.in_data  = in_data8;
    assign bus0.out_ready = out_ready[0];
    assign bus1.out_ready = out_ready[1];
    assign bus2.out_ready = out_ready[2];
    assign bus3.out_ready = out_ready[3];

    assign ov[0] = bus0.out_valid; assign ov[1] = bus1.out_valid;
    assign ov[2] = bus2.out_valid; assign ov[3] = bus3.out_valid;
    assign ir[0] = bus0.in_ready;  assign ir[1] = bus1.in_ready;
    assign ir[2] = bus2.in_ready;  assign ir[3] = bus3.in_ready;
    assign ol[0] = bus0.out_last;  assign ol[1] = bus1.out_last;
    assign ol[2] = bus2.out_last;  assign ol[3] = bus3.out_last;
    assign bz[0] = bus0.busy;      assign bz[1] = bus1.busy;
    assign bz[2] = bus2.busy;      assign bz[3] = bus3.busy;
    assign oc[0] = bus0.out_char;  assign oc[1] = bus1.out_char;
    assign oc[2] = bus2.out_char;  assign oc[3] = bus3.out_char;

    hex_string_serializer #(.DATA_WIDTH(16)) u_up (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    hex_string_serializer #(.DATA_WIDTH(16), .ZERO_SUPPRESS(1'b1)) u_zs (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    hex_string_serializer #(.DATA_WIDTH(16), .LOWERCASE(1'b1)) u_lc (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
    hex_string_serializer #(.DATA_WIDTH(8)) u_b8 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a word for one accepting edge, then scramble in_data so any
    // use of the live input would show up in the characters.
    task automatic send(input int s, input logic [15:0] d);
        in_valid[s] = 1'b1;
        if (s == 3) in_data8 = d[7:0];
        else        in_data[s] = d;
        @(negedge clk);
        in_valid[s] = 1'b0;
        if (s == 3) in_data8 = 8'hFF;
        else        in_data[s] = 16'hFFFF;
    endtask

    // Check the character on display, then let one edge pass.
    task automatic see(input int s, input string tag, input logic [7:0] c, input logic last);
        chk({tag, ".valid"}, 16'(ov[s]), 16'd1);
        chk({tag, ".char"},  16'(oc[s]), 16'(c));
        chk({tag, ".last"},  16'(ol[s]), 16'(last));
        @(negedge clk);
    endtask

    task automatic see_prefix(input int s, input string tag);
`ifdef HEX_PREFIX_EN
        see(s, {tag, ".p0"}, 8'h30, 1'b0);
        see(s, {tag, ".px"}, 8'h78, 1'b0);
`else
        chk({tag, ".busy"}, 16'(bz[s]), 16'd1);
`endif
    endtask

    task automatic idle_chk(input int s, input string tag);
        chk({tag, ".valid"}, 16'(ov[s]), 16'd0);
        chk({tag, ".char"},  16'(oc[s]), 16'h00);
        chk({tag, ".last"},  16'(ol[s]), 16'd0);
        chk({tag, ".ready"}, 16'(ir[s]), 16'd1);
        chk({tag, ".busy"},  16'(bz[s]), 16'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_data8 = 8'h00;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end
        for (int i = 0; i < 3; i++) in_data[i] = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.ready", 16'(ir[0]), 16'd0);
        chk("rst.valid", 16'(ov[0]), 16'd0);
        chk("rst.char",  16'(oc[0]), 16'h00);
        chk("rst.last",  16'(ol[0]), 16'd0);
        chk("rst.busy",  16'(bz[0]), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        idle_chk(0, "post_rst");

        // 0x3A0F streamed with the sink always ready
        send(0, 16'h3A0F);
        see_prefix(0, "w0");
        see(0, "w0.d3", 8'h33, 1'b0);
        see(0, "w0.d2", 8'h41, 1'b0);
        see(0, "w0.d1", 8'h30, 1'b0);
        see(0, "w0.d0", 8'h46, 1'b1);
        idle_chk(0, "w0.end");

        // Same word, sink stalls for three edges while 'A' is on display
        send(0, 16'h3A0F);
        see_prefix(0, "st");
        see(0, "st.d3", 8'h33, 1'b0);
        out_ready[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("st.hold.valid", 16'(ov[0]), 16'd1);
            chk("st.hold.char",  16'(oc[0]), 16'h41);
            chk("st.hold.last",  16'(ol[0]), 16'd0);
            if (i == 3) out_ready[0] = 1'b1;
            @(negedge clk);
        end
        see(0, "st.d1", 8'h30, 1'b0);
        see(0, "st.d0", 8'h46, 1'b1);
        idle_chk(0, "st.end");

        // Reset in the middle of a word discards the rest of it
        send(0, 16'h3A0F);
        see_prefix(0, "rw");
        see(0, "rw.d3", 8'h33, 1'b0);
        chk("rw.d2.char", 16'(oc[0]), 16'h41);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rw.rst.valid", 16'(ov[0]), 16'd0);
        chk("rw.rst.char",  16'(oc[0]), 16'h00);
        chk("rw.rst.busy",  16'(bz[0]), 16'd0);
        chk("rw.rst.ready", 16'(ir[0]), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        idle_chk(0, "rw.rel");
        for (int i = 0; i < 3; i++) begin
            chk("rw.quiet", 16'(ov[0]), 16'd0);
            @(negedge clk);
        end

        // Zero suppression
        send(1, 16'h000F);
        see_prefix(1, "zs0");
        see(1, "zs0.d0", 8'h46, 1'b1);
        idle_chk(1, "zs0.end");
        send(1, 16'h0000);
        see_prefix(1, "zs1");
        see(1, "zs1.d0", 8'h30, 1'b1);
        idle_chk(1, "zs1.end");
        send(1, 16'h0A00);
        see_prefix(1, "zs2");
        see(1, "zs2.d2", 8'h41, 1'b0);
        see(1, "zs2.d1", 8'h30, 1'b0);
        see(1, "zs2.d0", 8'h30, 1'b1);
        idle_chk(1, "zs2.end");

        // Lowercase digits
        send(2, 16'hABCD);
        see_prefix(2, "lc");
        see(2, "lc.d3", 8'h61, 1'b0);
        see(2, "lc.d2", 8'h62, 1'b0);
        see(2, "lc.d1", 8'h63, 1'b0);
        see(2, "lc.d0", 8'h64, 1'b1);
        idle_chk(2, "lc.end");

        // 8-bit word
        send(3, 16'h007E);
        see_prefix(3, "b8");
        see(3, "b8.d1", 8'h37, 1'b0);
        see(3, "b8.d0", 8'h45, 1'b1);
        idle_chk(3, "b8.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hex_string_serializer.md
HEX_STRING_SERIALIZER -- requirements
Module: hex_string_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of input word; SHALL be a multiple of 4 in range 4..64; NDIG = DATA_WIDTH/4 digits.
REQ-002 Parameter LOWERCASE, default 0: 0 selects digit characters "A"-"F" (0x41-0x46); 1 selects "a"-"f" (0x61-0x66).
REQ-003 Parameter ZERO_SUPPRESS, default 0: 1 skips leading zero nibbles, always emitting at least one digit.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 in_data  input  DATA_WIDTH  word to convert, MS nibble first.
REQ-009 out_valid  output  1  out_char is valid.
REQ-010 out_ready  input  1  sink accepts out_char this cycle.
REQ-011 out_char  output  8  ASCII character.
REQ-012 out_last  output  1  out_char is final character of current word.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 States SHALL be IDLE, PREFIX (only when HEX_PREFIX_EN defined), DIGITS.
REQ-015 in_ready SHALL equal 1 exactly when state is IDLE; an input handshake (in_valid & in_ready) SHALL capture in_data into an internal register and leave IDLE.
REQ-016 Digit mapping: nibble 0-9 -> 0x30-0x39; 10-15 -> per LOWERCASE; mapping purely from captured register, never from live in_data.
REQ-017 out_valid SHALL rise on the cycle after the input handshake (latency 1 cycle) and stay high until the final output handshake.
REQ-018 An output handshake (out_valid & out_ready) SHALL advance to the next character on the following cycle; while out_valid & !out_ready, out_char and out_last SHALL hold stable.
REQ-019 Digit index SHALL count down from start index to 0; start index = NDIG-1, or with ZERO_SUPPRESS=1 the index of the most significant nonzero nibble (0 when word is zero).
REQ-020 out_last SHALL be 1 only while presenting digit index 0.
REQ-021 Handshake on last character SHALL return state to IDLE; in_ready SHALL be 1 on the next cycle; no new word is accepted in the same cycle as the last output handshake.
REQ-022 In IDLE, out_valid and out_last SHALL be 0 and out_char SHALL be 0x00.

Reset
REQ-023 rst_n low at a rising edge SHALL force IDLE, out_valid=0, out_last=0, out_char=0x00, busy=0, digit index and data register to 0, regardless of in-progress word.
REQ-024 While rst_n is low, in_ready SHALL be 0; first cycle after release in_ready SHALL be 1.
REQ-025 A word interrupted by reset SHALL be discarded; no remaining characters emitted.

Configuration
REQ-026 Macro HEX_PREFIX_EN: when defined, each word SHALL begin with "0" (0x30) then "x" (0x78) in state PREFIX, each requiring its own output handshake, followed by digits; out_last never set on prefix characters.
REQ-027 When HEX_PREFIX_EN is undefined, PREFIX state and its logic SHALL not exist and the first character SHALL be the first digit.

Verification
REQ-028 DATA_WIDTH=16, in_data=0x3A0F, out_ready=1 -> out_char 0x33,0x41,0x30,0x46 on 4 consecutive cycles starting 1 cycle after accept; out_last only with 0x46; in_ready high next cycle.
REQ-029 Same word, out_ready low for 3 cycles while 0x41 presented -> 0x41 and out_last=0 held all 3 cycles, then 0x30 follows after out_ready returns.
REQ-030 ZERO_SUPPRESS=1, DATA_WIDTH=16: 0x000F -> single 0x46 with out_last=1; 0x0000 -> single 0x30 with out_last=1.
REQ-031 LOWERCASE=1, DATA_WIDTH=16, 0xABCD -> 0x61,0x62,0x63,0x64.
REQ-032 rst_n low for 1 cycle after second character of 0x3A0F -> next cycle out_valid=0, out_char=0x00, busy=0; after release in_ready=1, no further characters.
REQ-033 HEX_PREFIX_EN defined, DATA_WIDTH=8, 0x7E -> 0x30,0x78,0x37,0x45; out_last only with 0x45.
